// File: rtl/tx_bit_stuffer_if.sv
// tx_bit_stuffer_if: byte-level handshake between a packet source and the
// serial bit stuffer.
//   tx_data  [7:0] packet byte, transmitted LSB first
//   tx_valid       tx_data/tx_last valid
//   tx_last        final byte of the packet
//   tx_ready       stuffer holding register empty, byte can be accepted
// master = packet source, slave = tx_bit_stuffer.
interface tx_bit_stuffer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/tx_bit_stuffer.sv
// tx_bit_stuffer: serialises packet bytes LSB first behind a sync byte,
// inserting a 0 after every run of STUFF_LEN consecutive 1s, then holds the
// line idle for GAP_CYCLES cycles after each packet.
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   tx          byte handshake (slave side of tx_bit_stuffer_if)
//   s_data_out  serial bit to the NRZI line driver (0 while s_data_val=0)
//   s_data_val  serial bit valid; falling edge marks end of packet
//   busy        high from packet start through the end of the gap
//   underrun    one-cycle pulse when a non-last byte ends with nothing held
module tx_bit_stuffer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'h80,
  parameter int unsigned STUFF_LEN  = 6,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  tx_bit_stuffer_if.slave  tx,
  output logic             s_data_out,
  output logic             s_data_val,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, GAP} state_t;

  state_t        state, state_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shift, shift_d;
  logic          cur_last, cur_last_d;
  logic          in_sync, in_sync_d;
  logic [OW-1:0] ones, ones_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          hold_full, hold_full_d;
  logic [7:0]    hold_data, hold_data_d;
  logic          hold_last, hold_last_d;
  logic          out_d, val_d, busy_d, under_d;

  logic          adv, load, start_sync, emit_en, emit_bit, phase_sync;
  logic [2:0]    bit_inc;
  logic [OW-1:0] ones_base;

  assign tx.tx_ready = ~hold_full & ~rst;

  // Registered outputs always describe the bit currently on the line; the
  // next-state logic computes the following bit together with its state.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shift_d     = shift;
    cur_last_d  = cur_last;
    in_sync_d   = in_sync;
    ones_d      = ones;
    gap_d       = gap_cnt;
    hold_full_d = hold_full;
    hold_data_d = hold_data;
    hold_last_d = hold_last;
    out_d       = 1'b0;
    val_d       = 1'b0;
    busy_d      = busy;
    under_d     = 1'b0;
    adv         = 1'b0;
    load        = 1'b0;
    start_sync  = 1'b0;
    emit_en     = 1'b0;
    emit_bit    = 1'b0;
    ones_base   = ones;
    bit_inc     = bit_cnt + 3'd1;
    phase_sync  = (state == SYNC) || ((state == STUFF) && in_sync);

    if (tx.tx_valid && tx.tx_ready) begin
      hold_full_d = 1'b1;
      hold_data_d = tx.tx_data;
      hold_last_d = tx.tx_last;
    end

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (hold_full) start_sync = 1'b1;
      end
      SYNC, DATA: begin
        if (ones == STUFF_MAX) begin
          state_d   = STUFF;
          in_sync_d = (state == SYNC);
          val_d     = 1'b1;
          ones_d    = '0;
        end else begin
          adv = 1'b1;
        end
      end
      STUFF: adv = 1'b1;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_full) begin
            start_sync = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Continue the current byte, or take the byte-end decision (after any
    // stuff bit, since STUFF also arrives here with bit_cnt unchanged).
    if (adv) begin
      if (bit_cnt != 3'd7) begin
        bit_cnt_d = bit_inc;
        emit_en   = 1'b1;
        if (phase_sync) begin
          state_d  = SYNC;
          emit_bit = SYNC_BYTE[bit_inc];
        end else begin
          state_d  = DATA;
          emit_bit = shift[0];
          shift_d  = {1'b0, shift[7:1]};
        end
      end else if (phase_sync || (!cur_last && hold_full)) begin
        load = 1'b1;
      end else begin
        state_d = GAP;
        gap_d   = '0;
        under_d = ~cur_last;
      end
    end

    if (load) begin
      state_d     = DATA;
      bit_cnt_d   = '0;
      emit_en     = 1'b1;
      emit_bit    = hold_data[0];
      shift_d     = {1'b0, hold_data[7:1]};
      cur_last_d  = hold_last;
      hold_full_d = 1'b0;
    end

    if (start_sync) begin
      state_d   = SYNC;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      emit_en   = 1'b1;
      emit_bit  = SYNC_BYTE[0];
      ones_base = '0;
    end

    if (emit_en) begin
      val_d  = 1'b1;
      out_d  = emit_bit;
      ones_d = emit_bit ? ones_base + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      cur_last   <= 1'b0;
      in_sync    <= 1'b0;
      ones       <= '0;
      gap_cnt    <= '0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      s_data_out <= 1'b0;
      s_data_val <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      cur_last   <= cur_last_d;
      in_sync    <= in_sync_d;
      ones       <= ones_d;
      gap_cnt    <= gap_d;
      hold_full  <= hold_full_d;
      hold_data  <= hold_data_d;
      hold_last  <= hold_last_d;
      s_data_out <= out_d;
      s_data_val <= val_d;
      busy       <= busy_d;
      underrun   <= under_d;
    end
  end

endmodule

// File: tb/tb_tx_bit_stuffer.sv
module tb_tx_bit_stuffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_data_out, s_data_val, busy, underrun;

  tx_bit_stuffer_if tx_if ();

  tx_bit_stuffer #(
    .SYNC_BYTE  (8'h80),
    .STUFF_LEN  (6),
    .GAP_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (tx_if.slave),
    .s_data_out (s_data_out),
    .s_data_val (s_data_val),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected serial bits, filled by the reference model.
  logic exp_q[$];
  int   m_ones;
  int   exp_len;

  // Line monitor state.
  int hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0, gcnt = 0, under_cnt = 0;
  logic prev_val = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_bit(input logic b);
    exp_q.push_back(b);
    exp_len++;
    m_ones = b ? m_ones + 1 : 0;
    if (m_ones == 6) begin
      exp_q.push_back(1'b0);
      exp_len++;
      m_ones = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] x);
    for (int i = 0; i < 8; i++) model_bit(x[i]);
  endtask

  task automatic model_start();
    logic [7:0] s;
    s = 8'h80;
    m_ones  = 0;
    exp_len = 0;
    model_byte(s);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_if.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 0, 1);
    tx_if.tx_data  = d;
    tx_if.tx_last  = last;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    logic seen;
    seen = 1'b0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      if (seen && !busy) break;
      n++;
    end
    if (n >= 400) check("idle_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hi_run = 0;
      lo_run = 0;
      gcnt   = 0;
      prev_val = 1'b0;
    end else begin
      if (s_data_val) begin
        if (!prev_val) last_lo = lo_run;
        hi_run++;
        lo_run = 0;
        gcnt   = 0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $error("FAIL extra_bit: got=%0b exp=none", s_data_out);
        end else begin
          logic e;
          e = exp_q.pop_front();
          assert (s_data_out === e) else begin
            bad++;
            $error("FAIL serial_bit: got=%0b exp=%0b", s_data_out, e);
          end
        end
      end else begin
        if (prev_val) last_hi = hi_run;
        hi_run = 0;
        lo_run++;
        if (busy) gcnt++;
        total++;
        assert (s_data_out === 1'b0) else begin
          bad++;
          $error("FAIL out_idle: got=%0b exp=0", s_data_out);
        end
      end
      if (underrun) under_cnt++;
      prev_val = s_data_val;
    end
  end

  initial begin
    int u0, n;
    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_last  = 1'b0;

    // Reset state, asynchronous assertion.
    #2 rst = 1'b1;
    #1;
    check("rst_val",   int'(s_data_val), 0);
    check("rst_out",   int'(s_data_out), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_under", int'(underrun), 0);
    check("rst_ready", int'(tx_if.tx_ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", int'(tx_if.tx_ready), 1);

    // Single 0x00, last.
    model_start(); model_byte(8'h00);
    send_byte(8'h00, 1'b1);
    wait_idle();
    check("t1_hi_len", last_hi, 16);
    check("t1_gap", gcnt, 4);
    check("t1_q", exp_q.size(), 0);
    check("t1_under", under_cnt, 0);

    // Single 0xFF, last: one stuff bit inside the byte.
    model_start(); model_byte(8'hFF);
    send_byte(8'hFF, 1'b1);
    wait_idle();
    check("t2_hi_len", last_hi, 17);
    check("t2_q", exp_q.size(), 0);

    // 0x00 then 0xFC back-to-back: stuff bit after the final data bit.
    model_start(); model_byte(8'h00); model_byte(8'hFC);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFC, 1'b1);
    wait_idle();
    check("t3_hi_len", last_hi, 25);
    check("t3_gap", gcnt, 4);
    check("t3_q", exp_q.size(), 0);
    check("t3_under", under_cnt, 0);

    // Runs of ones spanning byte boundaries.
    model_start(); model_byte(8'hF0); model_byte(8'hFF); model_byte(8'h7E);
    check("t4_model_len", exp_len, 35);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h7E, 1'b1);
    wait_idle();
    check("t4_hi_len", last_hi, 35);
    check("t4_q", exp_q.size(), 0);

    // 0x55 not last, nothing follows: underrun abort.
    u0 = under_cnt;
    model_start(); model_byte(8'h55);
    send_byte(8'h55, 1'b0);
    wait_idle();
    check("t5_hi_len", last_hi, 16);
    check("t5_under_pulse", under_cnt - u0, 1);
    check("t5_gap", gcnt, 4);
    check("t5_q", exp_q.size(), 0);

    // Reset in the middle of DATA.
    u0 = under_cnt;
    model_start(); model_byte(8'h00);
    send_byte(8'h00, 1'b1);
    n = 0;
    while (!s_data_val && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("t6_start_timeout", 0, 1);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_val",  int'(s_data_val), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_out",  int'(s_data_out), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_under", under_cnt - u0, 0);
    check("t6_idle_busy", int'(busy), 0);
    model_start(); model_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    wait_idle();
    check("t6_new_hi_len", last_hi, 16);
    check("t6_q", exp_q.size(), 0);

    // Second packet accepted during the first packet's gap.
    model_start(); model_byte(8'h0F);
    model_start(); model_byte(8'hA5);
    send_byte(8'h0F, 1'b1);
    n = 0;
    while (!(busy && !s_data_val) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("t7_gap_timeout", 0, 1);
    send_byte(8'hA5, 1'b1);
    wait_idle();
    check("t7_between", last_lo, 4);
    check("t7_hi_len", last_hi, 16);
    check("t7_q", exp_q.size(), 0);
    check("t7_under", under_cnt - u0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_bit_stuffer.md
TX_BIT_STUFFER -- requirements
Module: tx_bit_stuffer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h80, sync pattern sent LSB first ahead of every packet.
REQ-002 SHALL have parameter STUFF_LEN, default 6, count of consecutive 1s that forces an inserted 0.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, minimum s_data_val-low cycles between packets (covers downstream EOP).
REQ-004 SHALL have one clock and an asynchronous, active-high reset; no other clock or reset inputs.
REQ-005 clk  input  1  sole clock, all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tx_data  input  8  packet byte, transmitted LSB first.
REQ-008 tx_valid  input  1  tx_data/tx_last valid.
REQ-009 tx_last  input  1  marks the final byte of a packet.
REQ-010 tx_ready  output  1  holding register empty, so a byte can be accepted.
REQ-011 s_data_out  output  1  serial bit to the NRZI line driver.
REQ-012 s_data_val  output  1  serial bit valid; a falling edge marks end of packet.
REQ-013 busy  output  1  high from packet start through the end of the gap.
REQ-014 underrun  output  1  one-cycle pulse when a non-last byte finishes and no next byte is held.

Function
REQ-015 SHALL accept a byte on any rising edge with tx_valid=1 and tx_ready=1.
- Byte and tx_last go into a 1-entry holding register.
- tx_ready = hold empty AND rst low.
REQ-016 SHALL implement states IDLE, SYNC, DATA, STUFF and GAP.
- All outputs are registered.
REQ-017 IDLE: s_data_val=0 and busy=0.
- When the holding register is full, go to SYNC.
- The accept edge is k; s_data_val rises with the first sync bit after edge k+1.
REQ-018 SYNC: drive SYNC_BYTE bit 0 to 7, one per cycle, with s_data_val=1.
- After bit 7, move the held byte into the shift register and go to DATA.
REQ-019 DATA: drive shift[0] for one cycle and shift right.
- The 8th bit ends the byte.
REQ-020 Ones counter:
- Cleared on entry to SYNC.
- Increments on each transmitted 1, including sync bits.
- Clears on any transmitted 0.
- Counts across byte boundaries.
REQ-021 When a transmitted 1 brings the ones counter to STUFF_LEN, the next cycle SHALL be STUFF.
- STUFF drives 0 with s_data_val=1 and clears the counter.
- Afterwards, resume the same byte, or take the byte-end decision.
REQ-022 Byte-end decision, taken after any pending stuff bit:
- tx_last=1: go to GAP.
- Hold full: load the next byte and stay in DATA with no bubble.
- Otherwise: pulse underrun and go to GAP; this aborts the packet.
REQ-023 s_data_val SHALL stay continuously high from the first sync bit to the last data or stuff bit.
- Valid-high length = 8 + 8·N + stuffed bits.
REQ-024 GAP: s_data_val=0, s_data_out=0, busy=1 for exactly GAP_CYCLES cycles, then return to IDLE.
- Bytes may be accepted during GAP.
- A packet held at the end of GAP starts SYNC on the next edge.
REQ-025 s_data_out SHALL be 0 whenever s_data_val=0.
REQ-026 tx_valid during SYNC, DATA or STUFF SHALL only fill an empty holding register and SHALL NOT disturb the bit in flight.

Reset
REQ-027 While rst=1, outputs SHALL be:
- s_data_out=0, s_data_val=0, busy=0, underrun=0, tx_ready=0.
- state=IDLE, holding register empty, ones counter=0.
- Takes effect immediately, without waiting for a clock edge.
REQ-028 Reset mid-packet SHALL abandon the packet with no stuff bit, no GAP and no underrun pulse.
- tx_ready=1 on the first edge after rst falls.

Verification
REQ-029 Single byte 0x00, last -> s_data_out = 0,0,0,0,0,0,0,1 then 0 ×8; s_data_val high 16 cycles, low 4 cycles; busy falls after the gap.
REQ-030 Single byte 0xFF, last -> sync, then 1,1,1,1,1,0(stuff),1,1,1; s_data_val high 17 cycles.
REQ-031 Bytes 0x00 then 0xFC (last), back-to-back -> stuff 0 after the final data bit; s_data_val high 25 cycles with no gap between bytes.
REQ-032 Byte 0x55, not last, no further byte -> s_data_val falls after 16 cycles; underrun=1 for exactly one cycle; GAP of 4 cycles.
REQ-033 rst pulsed mid-DATA -> s_data_val/busy drop asynchronously; no underrun; a new packet afterwards starts with a full sync.
REQ-034 Two packets queued (second byte accepted during GAP) -> exactly 4 cycles s_data_val=0 between packets; second packet begins with SYNC_BYTE.
